// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative radix-2 shift-add multiplier for MUL, MULH, MULHSU and MULHU.
// The operands are turned into unsigned magnitudes when they are accepted.
// Each RUN cycle makes one conditional add and shifts the {acc, mplier} pair right by one.
// FIX applies the sign and picks the requested half of the product.
//
// Ports:
//   clk     - clock; every state update happens on the rising edge
//   reset   - synchronous active-low reset
//   start   - request; accepted only in IDLE, and only when flush is low
//   flush   - aborts the operation in flight (pipeline kill)
//   op      - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a, b    - rs1 / rs2; sampled only on the edge that accepts start
//   busy    - high whenever the unit is not idle
//   done    - one-cycle pulse; result is valid
//   result  - registered result; held until the next completion or reset
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | XLEN shift-add iterations, counted by count_q
// FIX   | applies the sign and selects the half that result captures
// DONE  | done pulse cycle; returns to IDLE on the next edge

module seq_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod_raw;
  logic [2*XLEN-1:0] prod;
  logic              sign_a;
  logic              sign_b;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    count_d  = count_q;
    result_d = result_q;

    // An operand's sign counts only when the op treats that operand as signed.
    sign_a   = ((op == 2'b01) || (op == 2'b10)) && a[XLEN-1];
    sign_b   = (op == 2'b01) && b[XLEN-1];

    sum      = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : {XLEN{1'b0}})};
    prod_raw = {acc_q, mplier_q};
    prod     = neg_q ? (~prod_raw + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_raw;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d     = op;
          mcand_d  = sign_a ? (~a + {{(XLEN-1){1'b0}}, 1'b1}) : a;
          mplier_d = sign_b ? (~b + {{(XLEN-1){1'b0}}, 1'b1}) : b;
          neg_d    = sign_a ^ sign_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          // The carry of the add shifts into acc's MSB, and sum's LSB moves into mplier.
          acc_d    = sum[XLEN:1];
          mplier_d = {sum[0], mplier_q[XLEN-1:1]};
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(XLEN - 1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed bench for seq_mul_unit with hand-computed expected values.
module tb_seq_mul_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk;
  int n_bad;

  seq_mul_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge, so inputs change and outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op.
  // Index 0 is the cycle right after the accepting edge E0.
  // Input changes made at index i are sampled on edge E(i+1).
  task automatic run_op(input string tag, input logic [1:0] op_i,
                        input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [31:0] exp_res, input int exp_busy,
                        input int exp_done, input int poke_at, input int flush_at);
    int busy_cnt;
    int done_cnt;
    int done_idx;
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = -1;
    op = op_i; a = a_i; b = b_i; start = 1'b1; flush = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = i;
        chk({tag, "_res_at_done"}, result, exp_res);
      end
      start = (i == poke_at);
      flush = (i == flush_at);
      if (i == poke_at) begin
        a = 32'd3; b = 32'd3; op = 2'b00;
      end
      if (!busy && i > 0) break;
      tick();
    end
    start = 1'b0;
    flush = 1'b0;
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_done_pulses"}, done_cnt, exp_done);
    if (exp_done != 0) chk({tag, "_done_idx"}, done_idx, 32'd33);
    tick();
    tick();
    chk({tag, "_res_hold"}, result, exp_res);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);

    reset = 1'b1;
    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 34, 1, -1, -1);
    run_op("mulh_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 34, 1, -1, -1);
    run_op("mulhu_m1x2", 2'b11, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 34, 1, -1, -1);
    run_op("mul_m1x2", 2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 34, 1, -1, -1);
    run_op("mulh_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1, -1, -1);
    run_op("mulhsu_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1, -1, -1);

    // A start pulsed while RUN is active must be ignored.
    run_op("busy_start", 2'b00, 32'd7, 32'd6, 32'd42, 34, 1, 5, -1);
    // Flush sampled on edge E10: busy is high for 10 cycles, with no done pulse and result unchanged.
    run_op("flush_run", 2'b11, 32'd9, 32'd9, 32'd42, 10, 0, -1, 9);

    // Reset sampled on edge E5, during iteration 5.
    op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    start = 1'b1;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    tick();
    tick();
    chk("rst_hold_start_busy", {31'd0, busy}, 32'd0);
    // Reset is released with start already high, so the op begins on the first edge where reset=1.
    reset = 1'b1;
    run_op("post_rst", 2'b00, 32'd7, 32'd6, 32'd42, 34, 1, -1, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
